// File: rtl/uart_tx.sv
// uart_tx: serial transmitter draining a byte FIFO onto the tx line, 8N1 or 8E1.
//   Optional even parity compiled in when UART_TX_PARITY_EN is defined.
//   Ports: clk, reset (async, active high), enable, fifo_data/fifo_empty (FIFO head),
//   fifo_read_trig (pop pulse), tx (serial out, idles high), busy (frame on line).
//   tx and busy are registered from the current state, so the line trails the FSM
//   by one cycle; the pop pulse lands in the cycle before the start bit appears.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_read_trig,
  output logic       tx,
  output logic       busy
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q, par_d;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [W-1:0] div_q, div_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, busy_q, busy_d, trig_q, trig_d;
  logic last, load;
  assign fifo_read_trig = trig_q;
  assign tx = tx_q;
  assign busy = busy_q;
  always_comb begin
    last = div_q == LAST;
    load = enable && !fifo_empty;
    state_d = state_q;
    div_d = (state_q == IDLE || last) ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    trig_d = 1'b0;
    busy_d = state_q != IDLE;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
    tx_d = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : (state_q == PARITY) ? par_q : 1'b1;
`else
    tx_d = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
`endif
    case (state_q)
      IDLE: if (load) begin
        state_d = START;
        shift_d = fifo_data;
        trig_d = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d = ^fifo_data;
`endif
      end
      START: if (last) begin
        state_d = DATA;
        idx_d = 3'd0;
      end
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (last) state_d = STOP;
`endif
      STOP: if (last) begin
        // chain straight into the next start bit when another byte is waiting
        state_d = load ? START : IDLE;
        if (load) begin
          shift_d = fifo_data;
          trig_d = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d = ^fifo_data;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q <= '0;
      idx_q <= 3'd0;
      shift_q <= 8'd0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      trig_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      trig_q <= trig_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a FIFO model and a bit-level frame reference.
module tb_uart_tx;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef struct {
    logic [7:0] data;
    logic par;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic fifo_read_trig, tx, busy, fifo_empty;
  logic [7:0] fifo_data;
  logic [7:0] mem [64];
  int rd = 0;
  int wr = 0;
  int checks = 0;
  int fails = 0;
  int waited = 0;
  bit pending = 1'b0;
  vec_t tv [8];
  logic [7:0] rq [12];
  always #5 clk = ~clk;
  assign fifo_empty = (rd == wr);
  assign fifo_data = mem[rd[5:0]];
  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fifo_data(fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_read_trig(fifo_read_trig),
    .tx(tx),
    .busy(busy)
  );
  always @(posedge clk) if (fifo_read_trig) rd <= rd + 1;
  always @(negedge clk) if (fifo_read_trig) begin
    checks++;
    if (rd == wr) begin
      fails++;
      $display("FAIL pop_while_empty got=1 exp=0");
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic [7:0] b);
    mem[wr[5:0]] = b;
    wr++;
  endtask
  task automatic wait_pop();
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!fifo_read_trig && waited < 200);
    chk("pop_pulse", {31'd0, fifo_read_trig}, 1);
  endtask
  // frame reference: start 0, data LSB first, optional parity, stop 1; each bit C cycles
  task automatic expect_frame(input logic [7:0] b, input logic p, input int drop_at);
    logic [10:0] fr;
    int n, idx;
    fr = {1'b1, p, b, 1'b0};
    if (!pending) begin
      wait_pop();
      if (!fifo_read_trig) return;
    end
    pending = 1'b0;
    n = 0;
    for (int k = 0; k < NB * C; k++) begin
      @(negedge clk);
      if (k == drop_at) enable = 1'b0;
      idx = k / C;
      chk("tx_bit", {31'd0, tx}, {31'd0, (idx == NB - 1) ? fr[10] : fr[idx]});
      n += int'(busy);
      if (k < NB * C - 1) chk("single_pop", {31'd0, fifo_read_trig}, 0);
      else pending = fifo_read_trig;
    end
    chk("busy_cycles", n, NB * C);
  endtask
  initial begin
    int bad;
    tv[0] = '{8'h55, 1'b0};
    tv[1] = '{8'h07, 1'b1};
    tv[2] = '{8'h03, 1'b0};
    tv[3] = '{8'hA3, 1'b0};
    tv[4] = '{8'h0F, 1'b0};
    tv[5] = '{8'h80, 1'b1};
    tv[6] = '{8'hFF, 1'b0};
    tv[7] = '{8'h01, 1'b1};
    #2 reset = 1'b1;
    #1;
    chk("reset_tx", {31'd0, tx}, 1);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_trig", {31'd0, fifo_read_trig}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(tv[i].data);
      expect_frame(tv[i].data, tv[i].par, -1);
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_tx", {31'd0, tx}, 1);
    end
    push(8'hA3);
    push(8'h0F);
    expect_frame(8'hA3, 1'b0, -1);
    chk("b2b_contiguous", {31'd0, pending}, 1);
    expect_frame(8'h0F, 1'b0, -1);
    chk("b2b_pops", rd, wr);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_trig !== 1'b0) bad++;
    end
    chk("empty_idle", bad, 0);
    enable = 1'b0;
    push(8'h3C);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_read_trig !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("disabled_no_pop", bad, 0);
    enable = 1'b1;
    expect_frame(8'h3C, 1'b0, -1);
    chk("enable_latency", waited, 1);
    push(8'h5A);
    push(8'h11);
    expect_frame(8'h5A, 1'b0, 12);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (fifo_read_trig !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("drop_enable_no_pop", bad, 0);
    chk("drop_enable_left", wr - rd, 1);
    wr = rd;
    push(8'hC6);
    push(8'h39);
    enable = 1'b1;
    pending = 1'b0;
    wait_pop();
    repeat (18) @(negedge clk);
    chk("pre_reset_bit3", {31'd0, tx}, 0);
    reset = 1'b1;
    #1;
    chk("async_reset_tx", {31'd0, tx}, 1);
    chk("async_reset_busy", {31'd0, busy}, 0);
    chk("async_reset_trig", {31'd0, fifo_read_trig}, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("discarded_byte", wr - rd, 1);
    expect_frame(8'h39, 1'b0, -1);
    chk("post_reset_latency", waited, 1);
    for (int i = 0; i < 12; i++) begin
      rq[i] = 8'($urandom_range(0, 255));
      push(rq[i]);
    end
    for (int i = 0; i < 12; i++) expect_frame(rq[i], ^rq[i], -1);
    @(negedge clk);
    chk("random_drained", rd, wr);
    chk("random_idle", {31'd0, busy}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
